// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU issue path: function codes,
// operand-source encodings and the resolved issue entry.
package alu_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_func_e;

    localparam logic [3:0] FUNC_MAX = 4'd10;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2,
        OP1_RSVD = 2'd3
    } op1_src_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2,
        OP2_RSVD = 2'd3
    } op2_src_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   op1;
        logic [XLEN_DEF-1:0]   op2;
        alu_func_e             func;
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_write;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID -> issue -> EX bundle. master: the surrounding pipeline (ID, forwarding
// sources, EX consumer); slave: the issue stage itself.
interface alu_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic              id_ready;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_pc;
    logic [1:0]        id_op1_src;
    logic [1:0]        id_op2_src;
    logic [3:0]        id_alu_func;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              fwd_ex_valid;
    logic [REG_AW-1:0] fwd_ex_rd;
    logic [XLEN-1:0]   fwd_ex_data;
    logic              fwd_mem_valid;
    logic [REG_AW-1:0] fwd_mem_rd;
    logic [XLEN-1:0]   fwd_mem_data;
    logic              flush;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [3:0]        ALU_func;
    logic              ex_valid;
    logic              ex_ready;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              illegal_func;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_op1_src, id_op2_src, id_alu_func, id_rd, id_reg_write,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_data, flush, ex_ready,
        input  id_ready, op1, op2, ALU_func, ex_valid, ex_rd, ex_reg_write, illegal_func
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_op1_src, id_op2_src, id_alu_func, id_rd, id_reg_write,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_data, flush, ex_ready,
        output id_ready, op1, op2, ALU_func, ex_valid, ex_rd, ex_reg_write, illegal_func
    );
endinterface

// File: rtl/alu_operand_resolve.sv
// Combinational operand selection with EX/MEM forwarding. Produces the fully
// resolved entry that the issue buffer stores, plus the illegal-func flag.
module alu_operand_resolve
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [1:0]        op1_src,
    input  logic [1:0]        op2_src,
    input  logic [3:0]        alu_func,
    input  logic [REG_AW-1:0] rd,
    input  logic              reg_write,
    input  logic              fwd_ex_valid,
    input  logic [REG_AW-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]   fwd_ex_data,
    input  logic              fwd_mem_valid,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]   fwd_mem_data,
    output issue_entry_t      entry,
    output logic              illegal
);

    // x0 is hardwired zero; otherwise the youngest producer (EX) wins over MEM.
    function automatic logic [XLEN-1:0] fwd_value(input logic [REG_AW-1:0] idx,
                                                  input logic [XLEN-1:0]   rf_data);
        if (idx == '0)
            return '0;
        else if (fwd_ex_valid && (fwd_ex_rd == idx))
            return fwd_ex_data;
        else if (fwd_mem_valid && (fwd_mem_rd == idx))
            return fwd_mem_data;
        else
            return rf_data;
    endfunction

    // Source muxing, then an illegal func collapses to a harmless no-write ADD 0,0.
    always_comb begin
        entry           = '0;
        illegal         = (alu_func > FUNC_MAX);
        entry.rd        = rd;
        entry.reg_write = reg_write;
        entry.func      = alu_func_e'(alu_func);

        case (op1_src_e'(op1_src))
            OP1_RS1: entry.op1 = fwd_value(rs1, rs1_data);
            OP1_PC:  entry.op1 = pc;
            default: entry.op1 = '0;
        endcase

        case (op2_src_e'(op2_src))
            OP2_RS2:  entry.op2 = fwd_value(rs2, rs2_data);
            OP2_IMM:  entry.op2 = imm;
            OP2_FOUR: entry.op2 = XLEN'(4);
            default:  entry.op2 = '0;
        endcase

        if (illegal) begin
            entry.op1       = '0;
            entry.op2       = '0;
            entry.func      = ALU_ADD;
            entry.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// EX-stage ALU issue: accepts from ID, resolves operands at accept time and
// holds them in a head + skid pair so id_ready never depends on ex_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               CPU_CLK,
    input  logic               CPU_RST,
    alu_issue_stage_if.slave   bus
);

    issue_entry_t resolved;
    logic         resolved_illegal;

    issue_entry_t head_q, head_d, skid_q, skid_d;
    logic         head_valid_q, head_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         illegal_q, illegal_d;
    logic         accept, pop;

    alu_operand_resolve #(.XLEN(XLEN), .REG_AW(REG_AW)) u_resolve (
        .rs1           (bus.id_rs1),
        .rs2           (bus.id_rs2),
        .rs1_data      (bus.id_rs1_data),
        .rs2_data      (bus.id_rs2_data),
        .imm           (bus.id_imm),
        .pc            (bus.id_pc),
        .op1_src       (bus.id_op1_src),
        .op2_src       (bus.id_op2_src),
        .alu_func      (bus.id_alu_func),
        .rd            (bus.id_rd),
        .reg_write     (bus.id_reg_write),
        .fwd_ex_valid  (bus.fwd_ex_valid),
        .fwd_ex_rd     (bus.fwd_ex_rd),
        .fwd_ex_data   (bus.fwd_ex_data),
        .fwd_mem_valid (bus.fwd_mem_valid),
        .fwd_mem_rd    (bus.fwd_mem_rd),
        .fwd_mem_data  (bus.fwd_mem_data),
        .entry         (resolved),
        .illegal       (resolved_illegal)
    );

    // id_ready comes straight from a flop: space exists whenever the skid is empty.
    assign bus.id_ready = !skid_valid_q;
    assign accept       = bus.id_valid && !skid_valid_q;
    assign pop          = head_valid_q && bus.ex_ready;

    // Buffer next-state: flush wins, then skid->head refill, then new accepts.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        illegal_d    = 1'b0;

        if (bus.flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            illegal_d = accept && resolved_illegal;
            if (!head_valid_q || pop) begin
                if (skid_valid_q) begin
                    head_d       = skid_q;
                    head_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    head_d       = resolved;
                    head_valid_d = 1'b1;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = resolved;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset clears valids and zeroes the visible outputs.
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.ex_valid     = head_valid_q;
    assign bus.op1          = head_q.op1;
    assign bus.op2          = head_q.op2;
    assign bus.ALU_func     = head_q.func;
    assign bus.ex_rd        = head_q.rd;
    assign bus.ex_reg_write = head_q.reg_write;
    assign bus.illegal_func = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: forwarding, source muxing, illegal
// func, skid-buffer backpressure ordering, flush and asynchronous reset.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .CPU_CLK (clk),
        .CPU_RST (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid      = 1'b0;
        bus.id_rs1        = '0;
        bus.id_rs2        = '0;
        bus.id_rs1_data   = '0;
        bus.id_rs2_data   = '0;
        bus.id_imm        = '0;
        bus.id_pc         = '0;
        bus.id_op1_src    = 2'd0;
        bus.id_op2_src    = 2'd0;
        bus.id_alu_func   = 4'd3;
        bus.id_rd         = '0;
        bus.id_reg_write  = 1'b0;
        bus.fwd_ex_valid  = 1'b0;
        bus.fwd_ex_rd     = '0;
        bus.fwd_ex_data   = '0;
        bus.fwd_mem_valid = 1'b0;
        bus.fwd_mem_rd    = '0;
        bus.fwd_mem_data  = '0;
        bus.flush         = 1'b0;
    endtask

    // Present a PC + imm ADD tagged by pc so order is visible on op1/op2.
    task automatic present_pc(input logic [31:0] pc, input logic [4:0] rd);
        bus.id_valid     = 1'b1;
        bus.id_op1_src   = 2'd1;
        bus.id_op2_src   = 2'd1;
        bus.id_pc        = pc;
        bus.id_imm       = pc + 32'd1;
        bus.id_alu_func  = 4'd3;
        bus.id_rd        = rd;
        bus.id_reg_write = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();
        bus.ex_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
        chk("rst_illegal", 32'(bus.illegal_func), 32'd0);
        chk("rst_op1", bus.op1, 32'd0);
        chk("rst_op2", bus.op2, 32'd0);
        chk("rst_func", 32'(bus.ALU_func), 32'd0);
        chk("rst_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_rw", 32'(bus.ex_reg_write), 32'd0);
        rst_n = 1'b1;
        step();

        // ADD x5(=7) + imm 5
        bus.id_valid = 1'b1;  bus.id_rs1 = 5'd5;  bus.id_rs1_data = 32'd7;
        bus.id_op1_src = 2'd0; bus.id_op2_src = 2'd1; bus.id_imm = 32'd5;
        bus.id_alu_func = 4'd3; bus.id_rd = 5'd1; bus.id_reg_write = 1'b1;
        step();
        idle_inputs();
        chk("add_valid", 32'(bus.ex_valid), 32'd1);
        chk("add_op1", bus.op1, 32'd7);
        chk("add_op2", bus.op2, 32'd5);
        chk("add_func", 32'(bus.ALU_func), 32'd3);
        chk("add_rd", 32'(bus.ex_rd), 32'd1);
        chk("add_rw", 32'(bus.ex_reg_write), 32'd1);

        // EX forwarding beats MEM forwarding; op2 is the constant 4
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_data = 32'h11;
        bus.id_op1_src = 2'd0; bus.id_op2_src = 2'd2; bus.id_alu_func = 4'd4;
        bus.fwd_ex_valid = 1'b1;  bus.fwd_ex_rd = 5'd3;  bus.fwd_ex_data = 32'hAA;
        bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd3; bus.fwd_mem_data = 32'hBB;
        step();
        chk("fwd_ex_op1", bus.op1, 32'hAA);
        chk("fwd_ex_op2", bus.op2, 32'd4);
        chk("fwd_ex_func", 32'(bus.ALU_func), 32'd4);

        // MEM only, through rs2 on op2
        bus.fwd_ex_valid = 1'b0; bus.id_op2_src = 2'd0; bus.id_rs2 = 5'd3;
        bus.id_rs2_data = 32'h22;
        step();
        chk("fwd_mem_op1", bus.op1, 32'hBB);
        chk("fwd_mem_op2", bus.op2, 32'hBB);

        // No match: register-file data
        bus.fwd_mem_rd = 5'd9;
        step();
        chk("rf_op1", bus.op1, 32'h11);
        chk("rf_op2", bus.op2, 32'h22);

        // x0 ignores forwarding and register data
        bus.id_rs1 = 5'd0; bus.id_rs1_data = 32'h55;
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_rd = 5'd0; bus.fwd_ex_data = 32'hFF;
        step();
        chk("x0_op1", bus.op1, 32'd0);
        idle_inputs();

        // PC + const4; reserved op1 source reads zero
        bus.id_valid = 1'b1; bus.id_op1_src = 2'd1; bus.id_pc = 32'h100;
        bus.id_op2_src = 2'd2; bus.id_alu_func = 4'd3;
        step();
        chk("pc_op1", bus.op1, 32'h100);
        chk("pc_op2", bus.op2, 32'd4);
        bus.id_op1_src = 2'd3; bus.id_op2_src = 2'd3;
        step();
        chk("rsvd_op1", bus.op1, 32'd0);
        chk("rsvd_op2", bus.op2, 32'd0);
        idle_inputs();

        // Illegal func 12
        bus.id_valid = 1'b1; bus.id_op1_src = 2'd0; bus.id_rs1 = 5'd5;
        bus.id_rs1_data = 32'd7; bus.id_op2_src = 2'd1; bus.id_imm = 32'd9;
        bus.id_alu_func = 4'd12; bus.id_rd = 5'd6; bus.id_reg_write = 1'b1;
        step();
        idle_inputs();
        chk("ill_func", 32'(bus.ALU_func), 32'd3);
        chk("ill_op1", bus.op1, 32'd0);
        chk("ill_op2", bus.op2, 32'd0);
        chk("ill_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("ill_pulse", 32'(bus.illegal_func), 32'd1);
        step();
        chk("ill_pulse_end", 32'(bus.illegal_func), 32'd0);
        chk("ill_drained", 32'(bus.ex_valid), 32'd0);

        // Backpressure: A to head, B to skid, C waits
        bus.ex_ready = 1'b0;
        present_pc(32'hA0, 5'd10);
        step();
        chk("bp_a_valid", 32'(bus.ex_valid), 32'd1);
        chk("bp_a_op1", bus.op1, 32'hA0);
        chk("bp_rdy1", 32'(bus.id_ready), 32'd1);
        present_pc(32'hB0, 5'd11);
        step();
        chk("bp_rdy2", 32'(bus.id_ready), 32'd0);
        chk("bp_hold_op1", bus.op1, 32'hA0);
        present_pc(32'hC0, 5'd12);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_rdy_stall", 32'(bus.id_ready), 32'd0);
            chk("bp_stall_op1", bus.op1, 32'hA0);
            chk("bp_stall_op2", bus.op2, 32'hA1);
            chk("bp_stall_rd", 32'(bus.ex_rd), 32'd10);
        end
        bus.ex_ready = 1'b1;
        step();
        chk("bp_b_op1", bus.op1, 32'hB0);
        chk("bp_b_rd", 32'(bus.ex_rd), 32'd11);
        chk("bp_b_rdy", 32'(bus.id_ready), 32'd1);
        step();
        idle_inputs();
        chk("bp_c_op1", bus.op1, 32'hC0);
        chk("bp_c_op2", bus.op2, 32'hC1);
        chk("bp_c_valid", 32'(bus.ex_valid), 32'd1);
        step();
        chk("bp_empty", 32'(bus.ex_valid), 32'd0);

        // Flush with both entries full
        bus.ex_ready = 1'b0;
        present_pc(32'hD0, 5'd1);
        step();
        present_pc(32'hE0, 5'd2);
        step();
        chk("fl_full", 32'(bus.id_ready), 32'd0);
        present_pc(32'hF0, 5'd3);
        bus.flush = 1'b1;
        step();
        idle_inputs();
        chk("fl_valid", 32'(bus.ex_valid), 32'd0);
        chk("fl_rdy", 32'(bus.id_ready), 32'd1);

        // Flush in the same cycle as an accepted instruction drops it
        present_pc(32'h40, 5'd4);
        step();
        present_pc(32'h50, 5'd5);
        bus.flush = 1'b1;
        step();
        idle_inputs();
        bus.ex_ready = 1'b1;
        chk("fl2_valid", 32'(bus.ex_valid), 32'd0);
        chk("fl2_rdy", 32'(bus.id_ready), 32'd1);
        step();
        chk("fl2_never", 32'(bus.ex_valid), 32'd0);

        // Asynchronous reset mid-stall
        bus.ex_ready = 1'b0;
        present_pc(32'h60, 5'd6);
        step();
        present_pc(32'h70, 5'd7);
        step();
        idle_inputs();
        chk("ar_full", 32'(bus.id_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.ex_valid), 32'd0);
        chk("ar_rdy", 32'(bus.id_ready), 32'd1);
        chk("ar_op1", bus.op1, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after", 32'(bus.ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the EX-stage ALU interface. Drives op1/op2/ALU_func into the combinational ALU.
- Accepts decoded instructions from ID over a valid/ready handshake.
- Selects operand sources (register, PC, immediate, constant) and resolves EX/MEM forwarding.
- Registers the result into a 2-entry skid buffer, so backpressure from EX never creates a combinational ready path.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- CPU_CLK  in  1  sole clock; all state on the rising edge.
- CPU_RST  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage can accept this cycle.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_rs1_data  in  XLEN  register-file value for rs1.
- id_rs2_data  in  XLEN  register-file value for rs2.
- id_imm  in  XLEN  sign-extended immediate.
- id_pc  in  XLEN  instruction PC.
- id_op1_src  in  2  0=rs1, 1=PC, 2=zero, 3=reserved (treated as zero).
- id_op2_src  in  2  0=rs2, 1=imm, 2=const 4, 3=reserved (treated as zero).
- id_alu_func  in  4  ALU operation code.
- id_rd  in  5  destination index.
- id_reg_write  in  1  instruction writes rd.
- fwd_ex_valid  in  1  EX result forwarding candidate.
- fwd_ex_rd  in  5  EX result destination index.
- fwd_ex_data  in  XLEN  EX result value.
- fwd_mem_valid  in  1  MEM result forwarding candidate.
- fwd_mem_rd  in  5  MEM result destination index.
- fwd_mem_data  in  XLEN  MEM result value.
- flush  in  1  discard all buffered instructions.
- op1  out  XLEN  ALU operand 1.
- op2  out  XLEN  ALU operand 2.
- ALU_func  out  4  ALU operation.
- ex_valid  out  1  op1/op2/ALU_func valid.
- ex_ready  in  1  EX consumes the head this cycle.
- ex_rd  out  5  destination for the head entry.
- ex_reg_write  out  1  write enable for the head entry.
- illegal_func  out  1  one-cycle pulse on accepting an out-of-range func.

Behaviour:
- Reset (CPU_RST low, asynchronous): both entries invalid.
  - ex_valid=0, id_ready=1, illegal_func=0.
  - op1, op2, ALU_func, ex_rd, ex_reg_write all 0.
- Accept condition: id_valid & id_ready.
- Operands are resolved at accept and stored resolved, never re-resolved later.
- Forwarding applies only when the source select is rs1 (op1) or rs2 (op2).
  - Priority: EX match, then MEM match, then register-file data.
  - A match requires fwd_*_valid, equal index, and index != 0.
  - x0 always reads 0 regardless of id_rs*_data.
- Illegal func: id_alu_func > 10 on accept.
  - Stored as ADD with op1=op2=0 and ex_reg_write=0.
  - illegal_func pulses high the following cycle.
- Buffer: head register (drives outputs) plus skid register.
  - id_ready is registered: id_ready = !skid_valid.
  - Accept with head empty, or with head consumed this cycle (ex_ready & ex_valid) and skid empty → loads head; 1-cycle latency to ex_valid.
  - Accept while head held and skid empty → loads skid; id_ready drops next cycle.
  - Head consumed with skid valid → skid moves to head; skid empties; id_ready rises next cycle.
- Ordering: strictly FIFO, no reordering or duplication.
- Outputs stay stable while ex_valid & !ex_ready.
- flush (synchronous, highest priority):
  - Both entries invalidated next edge.
  - An instruction accepted in the same cycle is dropped.
  - id_ready=1 and ex_valid=0 the cycle after.
  - Output data registers keep old values (don't-care while invalid).
- Reset asserted mid-operation clears state immediately regardless of clock.

Decomposition:
- Shared package (alu_pkg): ALU_func codes SLL=0, SRL=1, SRA=2, ADD=3, SUB=4, XOR=5, OR=6, AND=7, SLT=8, SLTU=9, LUI=10; FUNC_MAX=10.
- Also in alu_pkg: op1_src/op2_src encodings, and the issue-entry struct {op1, op2, func, rd, reg_write}.
- One sub-module: alu_operand_resolve. Purely combinational mux plus forwarding priority, producing the resolved entry and the illegal flag.

Test Plan:
- Reset, then ADD (func=3) with rs1=x5=7, op2_src=imm=5, ex_ready=1 → next cycle ex_valid=1, op1=7, op2=5, ALU_func=3.
- rs1=x3, fwd_ex rd=3 data=0xAA, fwd_mem rd=3 data=0xBB → op1=0xAA. rs1=x0 with fwd_ex rd=0 data=0xFF → op1=0.
- ex_ready=0 for 4 cycles while ID streams A, B, C:
  - A held in head, B in skid, id_ready=0 from cycle 3, C is not accepted.
  - Releasing ex_ready gives order A, B, C with no loss.
- op1_src=PC (pc=0x100), op2_src=const4, func=ADD → op1=0x100, op2=4.
- func=12 accepted → ALU_func=3, op1=op2=0, ex_reg_write=0, illegal_func high for exactly one cycle.
- Both entries full, then flush together with id_valid → next cycle ex_valid=0, id_ready=1, flushed-cycle instruction never appears. CPU_RST low mid-stall also clears immediately.
